// File: rtl/rate_divider.sv
// rate_divider: turns a 0..MAX_LVL level into a 50%-duty slow_clk and a one-cycle tick on each rising slow_clk.
// Ports: CLK_50 clock, reset async active-low, run (1 = count, 0 = idle), freq_num requested level in,
//        slow_clk / tick / lvl_active out, all driven straight from flops.
// Latency: freq_num -> freq_q 1 cycle; freq_q reaches lvl_active only at a half-period boundary. No backpressure.
module rate_divider #(
  parameter int DIV_BASE = 25000000,
  parameter int CNT_W    = 25,
  parameter int MAX_LVL  = 5
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic       run,
  input  logic [2:0] freq_num,
  output logic       slow_clk,
  output logic       tick,
  output logic [2:0] lvl_active
);

  // One extra bit on the half-period so DIV_BASE == 2^CNT_W still fits;
  // the counter itself only ever reaches half-1.
  localparam logic [CNT_W:0] BASE    = (CNT_W+1)'(DIV_BASE);
  localparam logic [2:0]     LVL_MAX = 3'(MAX_LVL);

  logic [2:0]       freq_q;
  logic [2:0]       freq_clamp;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   half;
  logic             boundary;

  always_comb begin
    freq_clamp = (freq_num > LVL_MAX) ? LVL_MAX : freq_num;
    half       = BASE >> lvl_active;
    boundary   = ({1'b0, cnt} == (half - (CNT_W+1)'(1)));
  end

  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      slow_clk   <= 1'b0;
      tick       <= 1'b0;
      lvl_active <= 3'd0;
      freq_q     <= 3'd0;
    end else begin
      freq_q <= freq_clamp;
      if (!run) begin
        // Idle wins over a coincident boundary; keep tracking the requested
        // level so the first phase after run rises already uses it.
        cnt        <= '0;
        slow_clk   <= 1'b0;
        tick       <= 1'b0;
        lvl_active <= freq_q;
      end else if (boundary) begin
        // New level is latched here so it governs the whole next phase.
        cnt        <= '0;
        slow_clk   <= ~slow_clk;
        tick       <= ~slow_clk;   // only on the low-to-high toggle
        lvl_active <= freq_q;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rate_divider.sv
module tb_rate_divider;
  localparam int DIV_BASE = 64;
  localparam int CNT_W    = 6;
  localparam int MAX_LVL  = 5;

  logic       CLK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [2:0] freq_num = 3'd0;
  logic       slow_clk;
  logic       tick;
  logic [2:0] lvl_active;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remaining-cycles view of the current phase.
  int   m_fq, m_lvl, m_left;
  logic m_slow, m_tick;

  always #5 CLK_50 = ~CLK_50;

  rate_divider #(.DIV_BASE(DIV_BASE), .CNT_W(CNT_W), .MAX_LVL(MAX_LVL)) dut (
    .CLK_50(CLK_50), .reset(reset), .run(run), .freq_num(freq_num),
    .slow_clk(slow_clk), .tick(tick), .lvl_active(lvl_active)
  );

  function automatic int clamp_lvl(input int f);
    return (f > MAX_LVL) ? MAX_LVL : f;
  endfunction

  task automatic m_reset();
    m_fq = 0; m_lvl = 0; m_left = DIV_BASE; m_slow = 1'b0; m_tick = 1'b0;
  endtask

  // A phase lasts DIV_BASE >> level cycles; the level sampled at the start
  // of a phase is the clamped request as registered one cycle earlier.
  task automatic m_edge(input logic r, input int f);
    m_tick = 1'b0;
    if (!r) begin
      m_slow = 1'b0;
      m_lvl  = m_fq;
      m_left = DIV_BASE >> m_lvl;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_slow = ~m_slow;
        m_tick = m_slow;
        m_lvl  = m_fq;
        m_left = DIV_BASE >> m_lvl;
      end
    end
    m_fq = clamp_lvl(f);
  endtask

  // Drive inputs away from the edge, clock once, update model, settle.
  task automatic cyc(input logic r, input logic [2:0] f);
    run = r; freq_num = f;
    @(posedge CLK_50);
    if (reset) m_edge(r, int'(f)); else m_reset();
    #1;
  endtask

  task automatic do_reset(input logic [2:0] f);
    reset = 1'b0; m_reset();
    repeat (2) cyc(1'b1, f);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int first_tick;
    first_tick = -1;
    run = 1'b1; freq_num = 3'd0;
    repeat (3) begin
      cyc(1'b1, 3'd0);
      n_vec++;
      if ({slow_clk, tick, lvl_active} !== 5'b0) begin
        n_err++; $display("FAIL reset_hold: got %b want 00000", {slow_clk, tick, lvl_active});
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= 140; i++) begin
      cyc(1'b1, 3'd0);
      if (tick && first_tick < 0) first_tick = i;
      n_vec++;
      if ({slow_clk, tick, lvl_active} !== {m_slow, m_tick, 3'(m_lvl)}) begin
        n_err++; $display("FAIL reset_run cyc %0d: got %b want %b", i, {slow_clk, tick, lvl_active}, {m_slow, m_tick, 3'(m_lvl)});
      end
    end
    n_vec++;
    if (first_tick !== 64) begin
      n_err++; $display("FAIL first_tick: got %0d want 64", first_tick);
    end
  endtask

  task automatic test_fast_start();
    int nt;
    nt = 0;
    do_reset(3'd5);
    for (int i = 1; i <= 100; i++) begin
      cyc(1'b1, 3'd5);
      if (i > 64 && tick) nt++;
      n_vec++;
      if ({slow_clk, tick, lvl_active} !== {m_slow, m_tick, 3'(m_lvl)}) begin
        n_err++; $display("FAIL fast_start cyc %0d: got %b want %b", i, {slow_clk, tick, lvl_active}, {m_slow, m_tick, 3'(m_lvl)});
      end
    end
    n_vec++;
    if (lvl_active !== 3'd5 || nt !== 9) begin
      n_err++; $display("FAIL fast_level: got lvl %0d ticks %0d want lvl 5 ticks 9", lvl_active, nt);
    end
  endtask

  task automatic test_mid_change();
    int q[$];
    int len, bad, waited;
    logic prev;
    bad = 0; waited = 0;
    do_reset(3'd0);
    while (!tick && waited < 80) begin
      cyc(1'b1, 3'd0); waited++;
      n_vec++;
      if ({slow_clk, tick, lvl_active} !== {m_slow, m_tick, 3'(m_lvl)}) begin
        n_err++; $display("FAIL mid_pre: got %b want %b", {slow_clk, tick, lvl_active}, {m_slow, m_tick, 3'(m_lvl)});
      end
    end
    n_vec++;
    if (!tick) begin n_err++; $display("FAIL mid_wait: got no tick want tick within 80"); end
    len = 1; prev = slow_clk;
    for (int i = 2; i <= 200; i++) begin
      cyc(1'b1, (i >= 10) ? 3'd3 : 3'd0);
      if (slow_clk === prev) len++;
      else begin q.push_back(len); len = 1; prev = slow_clk; end
      n_vec++;
      if ({slow_clk, tick, lvl_active} !== {m_slow, m_tick, 3'(m_lvl)}) begin
        n_err++; $display("FAIL mid_change cyc %0d: got %b want %b", i, {slow_clk, tick, lvl_active}, {m_slow, m_tick, 3'(m_lvl)});
      end
    end
    for (int k = 1; k < q.size(); k++) if (q[k] != 8) bad++;
    n_vec++;
    if (q.size() < 5 || q[0] != 64 || bad != 0) begin
      n_err++; $display("FAIL mid_phases: got n=%0d first=%0d bad=%0d want first=64 rest=8", q.size(), (q.size() > 0) ? q[0] : -1, bad);
    end
  endtask

  task automatic test_clamp();
    int gap, w;
    gap = 0; w = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 3'd7);
      n_vec++;
      if ({slow_clk, tick, lvl_active} !== {m_slow, m_tick, 3'(m_lvl)}) begin
        n_err++; $display("FAIL clamp cyc %0d: got %b want %b", i, {slow_clk, tick, lvl_active}, {m_slow, m_tick, 3'(m_lvl)});
      end
    end
    n_vec++;
    if (lvl_active !== 3'd5) begin n_err++; $display("FAIL clamp_lvl: got %0d want 5", lvl_active); end
    while (!tick && w < 10) begin cyc(1'b1, 3'd7); w++; end
    do begin cyc(1'b1, 3'd7); gap++; end while (!tick && gap < 10);
    n_vec++;
    if (gap !== 4) begin n_err++; $display("FAIL clamp_period: got %0d want 4", gap); end
  endtask

  task automatic test_run_drop();
    int w, n;
    w = 0; n = 0;
    while (!(tick && lvl_active == 3'd2) && w < 100) begin cyc(1'b1, 3'd2); w++; end
    repeat (5) cyc(1'b1, 3'd2);
    cyc(1'b0, 3'd2);
    n_vec++;
    if ({slow_clk, tick} !== 2'b00 || {slow_clk, tick, lvl_active} !== {m_slow, m_tick, 3'(m_lvl)}) begin
      n_err++; $display("FAIL run_drop: got %b want %b", {slow_clk, tick, lvl_active}, {m_slow, m_tick, 3'(m_lvl)});
    end
    repeat (3) cyc(1'b0, 3'd2);
    do begin
      cyc(1'b1, 3'd2); n++;
      n_vec++;
      if ({slow_clk, tick, lvl_active} !== {m_slow, m_tick, 3'(m_lvl)}) begin
        n_err++; $display("FAIL run_restore cyc %0d: got %b want %b", n, {slow_clk, tick, lvl_active}, {m_slow, m_tick, 3'(m_lvl)});
      end
    end while (!tick && n < 40);
    n_vec++;
    if (n !== 16 || slow_clk !== 1'b1) begin
      n_err++; $display("FAIL run_restart: got %0d cycles slow %b want 16 cycles slow 1", n, slow_clk);
    end
  endtask

  task automatic test_async_reset();
    int w, first_tick;
    w = 0; first_tick = -1;
    while (!tick && w < 40) begin cyc(1'b1, 3'd2); w++; end
    repeat (3) cyc(1'b1, 3'd2);
    #3 reset = 1'b0;
    #1;
    m_reset();
    n_vec++;
    if ({slow_clk, tick, lvl_active} !== 5'b0) begin
      n_err++; $display("FAIL async_reset: got %b want 00000", {slow_clk, tick, lvl_active});
    end
    repeat (2) cyc(1'b1, 3'd0);
    reset = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      cyc(1'b1, 3'd0);
      if (tick && first_tick < 0) first_tick = i;
      n_vec++;
      if ({slow_clk, tick, lvl_active} !== {m_slow, m_tick, 3'(m_lvl)}) begin
        n_err++; $display("FAIL async_resume cyc %0d: got %b want %b", i, {slow_clk, tick, lvl_active}, {m_slow, m_tick, 3'(m_lvl)});
      end
    end
    n_vec++;
    if (first_tick !== 64) begin n_err++; $display("FAIL async_first_tick: got %0d want 64", first_tick); end
  endtask

  task automatic test_random();
    logic       r;
    logic [2:0] f;
    r = 1'b1; f = 3'd4;
    do_reset(f);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < (r ? 2 : 30)) r = ~r;
      cyc(r, f);
      n_vec++;
      if ({slow_clk, tick, lvl_active} !== {m_slow, m_tick, 3'(m_lvl)}) begin
        n_err++; $display("FAIL random cyc %0d: got %b want %b", i, {slow_clk, tick, lvl_active}, {m_slow, m_tick, 3'(m_lvl)});
      end
    end
  endtask

  initial begin
    m_reset();
    #2;
    test_reset();
    test_fast_start();
    test_mid_change();
    test_clamp();
    test_run_drop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
